// File: rtl/demux32_rr_scheduler.sv
// Round-robin sequencer for a 1:32 bit demultiplexer: steps the select across the
// enabled channels, captures each accepted bit and counts completed frames.
module demux32_rr_scheduler (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] chan_en,
    input  logic        in_valid,
    input  logic        in,
    output logic        in_ready,
    output logic [4:0]  sel,
    output logic [31:0] y,
    output logic        frame_done,
    output logic [7:0]  frame_cnt
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [4:0]  ptr_q, ptr_d;
    logic [31:0] en_q, en_d;
    logic [31:0] y_q, y_d;
    logic        frame_done_q, frame_done_d;
    logic [7:0]  frame_cnt_q, frame_cnt_d;
    logic        accept_s;
    logic [5:0]  next_s;

    // Index of the lowest set bit; zero for an empty mask.
    function automatic logic [4:0] lowest_set(input logic [31:0] m);
        logic [4:0] idx;
        logic       found;
        idx   = 5'd0;
        found = 1'b0;
        for (int i = 0; i < 32; i++) begin
            if (m[i] && !found) begin
                idx   = 5'(i);
                found = 1'b1;
            end else begin
                found = found;
            end
        end
        return idx;
    endfunction

    // Next set bit strictly above p; bit 5 flags that one exists.
    function automatic logic [5:0] next_above(input logic [31:0] m, input logic [4:0] p);
        logic [4:0] idx;
        logic       found;
        idx   = 5'd0;
        found = 1'b0;
        for (int i = 0; i < 32; i++) begin
            if (m[i] && (i > int'(p)) && !found) begin
                idx   = 5'(i);
                found = 1'b1;
            end else begin
                found = found;
            end
        end
        return {found, idx};
    endfunction

    // Handshake and scan position derive only from registered state.
    always_comb begin
        accept_s = in_valid && (state_q == ST_RUN);
        next_s   = next_above(en_q, ptr_q);
    end

    // Next-state, pointer advance, capture and frame accounting.
    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        en_d         = en_q;
        y_d          = y_q;
        frame_done_d = 1'b0;
        frame_cnt_d  = frame_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (chan_en != 32'd0) begin
                    en_d    = chan_en;
                    ptr_d   = lowest_set(chan_en);
                    state_d = ST_RUN;
                end else begin
                    ptr_d   = 5'd0;
                end
            end
            ST_RUN: begin
                if (accept_s) begin
                    y_d[ptr_q] = in;
                    if (next_s[5]) begin
                        ptr_d = next_s[4:0];
                    end else begin
                        // Frame end: the mask is re-sampled here so mid-frame edits wait.
                        frame_done_d = 1'b1;
                        frame_cnt_d  = frame_cnt_q + 8'd1;
                        en_d         = chan_en;
                        if (chan_en != 32'd0) begin
                            ptr_d = lowest_set(chan_en);
                        end else begin
                            ptr_d   = 5'd0;
                            state_d = ST_IDLE;
                        end
                    end
                end else begin
                    ptr_d = ptr_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
                ptr_d   = 5'd0;
            end
        endcase
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            ptr_q        <= 5'd0;
            en_q         <= 32'd0;
            y_q          <= 32'd0;
            frame_done_q <= 1'b0;
            frame_cnt_q  <= 8'd0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            en_q         <= en_d;
            y_q          <= y_d;
            frame_done_q <= frame_done_d;
            frame_cnt_q  <= frame_cnt_d;
        end
    end

    assign in_ready   = (state_q == ST_RUN);
    assign sel        = ptr_q;
    assign y          = y_q;
    assign frame_done = frame_done_q;
    assign frame_cnt  = frame_cnt_q;

endmodule

// File: tb/tb_demux32_rr_scheduler.sv
// Bench for demux32_rr_scheduler: directed scenarios plus random traffic, all
// compared every cycle against a channel-order queue model.
module tb_demux32_rr_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] chan_en;
    logic        in_valid;
    logic        in_bit;
    logic        in_ready;
    logic [4:0]  sel;
    logic [31:0] y;
    logic        frame_done;
    logic [7:0]  frame_cnt;

    int total = 0;
    int bad   = 0;

    demux32_rr_scheduler dut (
        .clk(clk), .rst(rst), .chan_en(chan_en), .in_valid(in_valid), .in(in_bit),
        .in_ready(in_ready), .sel(sel), .y(y), .frame_done(frame_done), .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    // Model: ordered list of the frame's channels and a position within it.
    int          m_order[$];
    int          m_pos;
    bit          m_run;
    logic [31:0] m_y;
    bit          m_done;
    logic [7:0]  m_cnt;

    function automatic void build_order(input logic [31:0] m);
        m_order.delete();
        for (int i = 0; i < 32; i++)
            if (m[i]) m_order.push_back(i);
        m_pos = 0;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_run = 1'b0; m_pos = 0; m_y = 32'd0; m_done = 1'b0; m_cnt = 8'd0;
            m_order.delete();
        end else begin
            m_done = 1'b0;
            if (!m_run) begin
                if (chan_en != 32'd0) begin
                    build_order(chan_en);
                    m_run = 1'b1;
                end
            end else if (in_valid) begin
                m_y[m_order[m_pos]] = in_bit;
                if (m_pos == m_order.size() - 1) begin
                    m_done = 1'b1;
                    m_cnt  = m_cnt + 8'd1;
                    if (chan_en != 32'd0) build_order(chan_en);
                    else m_run = 1'b0;
                end else begin
                    m_pos++;
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        int es;
        es = m_run ? m_order[m_pos] : 0;
        check("m_in_ready", {31'd0, in_ready}, {31'd0, m_run});
        check("m_sel", {27'd0, sel}, 32'(es));
        check("m_y", y, m_y);
        check("m_frame_done", {31'd0, frame_done}, {31'd0, m_done});
        check("m_frame_cnt", {24'd0, frame_cnt}, {24'd0, m_cnt});
    end

    task automatic step(input logic v, input logic b);
        in_valid = v;
        in_bit   = b;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        logic [31:0] sparse_sel [6];
        rst = 1'b1; chan_en = 32'd0; in_valid = 1'b0; in_bit = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (3) step(1'b1, 1'b1);
        check("idle_ready", {31'd0, in_ready}, 32'd0);

        // Full mask, alternating bits starting with 1.
        chan_en = 32'hFFFF_FFFF;
        step(1'b0, 1'b0);
        check("run_ready", {31'd0, in_ready}, 32'd1);
        for (int i = 0; i < 32; i++) begin
            check("full_sel", {27'd0, sel}, 32'(i));
            step(1'b1, (i % 2) == 0);
        end
        in_valid = 1'b0;
        check("full_y", y, 32'h5555_5555);
        check("full_cnt", {24'd0, frame_cnt}, 32'd1);
        check("full_done", {31'd0, frame_done}, 32'd1);
        check("full_sel_wrap", {27'd0, sel}, 32'd0);
        step(1'b1, 1'b1);
        step(1'b1, 1'b0);

        // Asynchronous reset in the middle of a frame.
        #2;
        rst = 1'b1;
        chan_en = 32'd0;
        #1;
        check("arst_ready", {31'd0, in_ready}, 32'd0);
        check("arst_sel", {27'd0, sel}, 32'd0);
        check("arst_y", y, 32'd0);
        check("arst_cnt", {24'd0, frame_cnt}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (2) step(1'b0, 1'b0);
        check("arst_idle_ready", {31'd0, in_ready}, 32'd0);

        // Sparse mask.
        sparse_sel = '{32'd0, 32'd4, 32'd31, 32'd0, 32'd4, 32'd31};
        chan_en = 32'h8000_0011;
        step(1'b0, 1'b0);
        for (int i = 0; i < 6; i++) begin
            check("sparse_sel", {27'd0, sel}, sparse_sel[i]);
            step(1'b1, i < 3);
        end
        in_valid = 1'b0;
        check("sparse_y", y & 32'h8000_0011, 32'd0);
        check("sparse_cnt", {24'd0, frame_cnt}, 32'd2);

        // Mid-frame mask change is deferred to the frame end.
        do_reset();
        chan_en = 32'h0000_000F;
        step(1'b0, 1'b0);
        step(1'b1, 1'b1);
        step(1'b1, 1'b1);
        chan_en = 32'h0000_0002;
        check("mid_sel2", {27'd0, sel}, 32'd2);
        step(1'b1, 1'b0);
        check("mid_sel3", {27'd0, sel}, 32'd3);
        step(1'b1, 1'b1);
        check("mid_sel1", {27'd0, sel}, 32'd1);
        step(1'b1, 1'b0);
        check("mid_sel1_again", {27'd0, sel}, 32'd1);

        // Back-pressure gaps.
        chan_en = 32'h0000_00F0;
        for (int r = 0; r < 3; r++) begin
            step(1'b1, 1'($urandom));
            step(1'b0, 1'($urandom));
            step(1'b0, 1'($urandom));
            step(1'b1, 1'($urandom));
        end

        // Drain to idle.
        do_reset();
        chan_en = 32'h0000_0003;
        step(1'b0, 1'b0);
        step(1'b1, 1'b1);
        chan_en = 32'd0;
        step(1'b1, 1'b1);
        in_valid = 1'b0;
        check("drain_done", {31'd0, frame_done}, 32'd1);
        check("drain_ready", {31'd0, in_ready}, 32'd0);
        check("drain_sel", {27'd0, sel}, 32'd0);
        step(1'b1, 1'b0);
        check("drain_ready2", {31'd0, in_ready}, 32'd0);

        // Frame counter wrap with a single-channel mask.
        do_reset();
        chan_en = 32'h0000_0001;
        step(1'b0, 1'b0);
        repeat (255) step(1'b1, 1'($urandom));
        check("wrap_255", {24'd0, frame_cnt}, 32'd255);
        step(1'b1, 1'b0);
        check("wrap_0", {24'd0, frame_cnt}, 32'd0);
        check("wrap_done", {31'd0, frame_done}, 32'd1);

        // Random traffic with occasional mask edits and one async reset.
        for (int i = 0; i < 3000; i++) begin
            int r;
            r = $urandom_range(0, 15);
            if (r == 0) chan_en = 32'd0;
            else if (r == 1) chan_en = 32'd1 << $urandom_range(0, 31);
            else if (r < 4) chan_en = $urandom & $urandom;
            else if (r == 4) chan_en = $urandom;
            if (i == 1500) begin
                #3;
                rst = 1'b1;
                #1;
                check("rand_arst_y", y, 32'd0);
                @(posedge clk);
                #1;
                rst = 1'b0;
            end
            step($urandom_range(0, 3) != 0, 1'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
